// File: rtl/id_branch_hazard_unit_pkg.sv
// id_branch_hazard_unit_pkg: shared condition codes, opcodes, scoreboard entry and instruction classes
package id_branch_hazard_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       sets_flags;
  } sb_entry_t;
  typedef enum logic [1:0] {CLS_BUBBLE, CLS_BRANCH, CLS_DP, CLS_OTHER} instr_class_t;
  function automatic logic [31:0] branch_offset(input logic [23:0] imm);
    return {{6{imm[23]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/id_branch_hazard_unit_cond.sv
// cond_check: evaluates an ARM condition field against NZCV flags
// Ports: i_cond - condition field [31:28]; i_status - NZCV (N=bit3); o_pass - condition holds
module cond_check
  import id_branch_hazard_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_status,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_status;
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = w_n == w_v;
      COND_LT: o_pass = w_n != w_v;
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/id_branch_hazard_unit.sv
// id_branch_hazard_unit: decode-stage RAW/flag hazard detection, branch resolution and ID/EX register
// Ports: clk/rst - clock, sync active-high reset; if_id_* - IF/ID register; status - NZCV flags;
//        freeze/flush/branchTaken/branchAddr - to fetch; id_ex_* - ID/EX register;
//        stall_cnt/branch_cnt - saturating performance counters
module id_branch_hazard_unit
  import id_branch_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_id_pc,
  input  logic [31:0]      if_id_instruction,
  input  logic [3:0]       status,
  output logic             freeze,
  output logic             flush,
  output logic             branchTaken,
  output logic [31:0]      branchAddr,
  output logic             id_ex_valid,
  output logic [31:0]      id_ex_pc,
  output logic [31:0]      id_ex_instruction,
  output logic [3:0]       id_ex_dest,
  output logic             id_ex_wb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] branch_cnt
);
  instr_class_t    w_cls;
  logic [3:0]      w_cond, w_rn, w_rm, w_rd, w_opc, w_dest;
  logic            w_use_rn, w_use_rm, w_cond_ok, w_hazard, w_taken, w_wb, w_bl;
  sb_entry_t       w_nxt;
  sb_entry_t       r_sb [2];
  logic [31:0]     r_pc, r_ins;
  logic [CNT_W-1:0] r_stall, r_br;
  assign w_cond = if_id_instruction[31:28];
  assign w_opc  = if_id_instruction[24:21];
  assign w_rn   = if_id_instruction[19:16];
  assign w_rd   = if_id_instruction[15:12];
  assign w_rm   = if_id_instruction[3:0];
  assign w_cls  = (if_id_instruction == 32'h0)          ? CLS_BUBBLE :
                  (if_id_instruction[27:25] == 3'b101)  ? CLS_BRANCH :
                  (if_id_instruction[27:26] == 2'b00)   ? CLS_DP     : CLS_OTHER;
  assign w_bl     = w_cls == CLS_BRANCH && if_id_instruction[24];
  assign w_use_rn = w_cls == CLS_DP;
  assign w_use_rm = w_use_rn && !if_id_instruction[25];
  cond_check u_cond (
    .i_cond  (w_cond),
    .i_status(status),
    .o_pass  (w_cond_ok)
  );
  // Only in-flight entries that will write back matter for RAW; any in-flight
  // flag setter blocks a conditional branch until its flags are architectural.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < 2; i++)
      w_hazard = w_hazard | (r_sb[i].valid &&
        ((r_sb[i].wb_en && ((w_use_rn && w_rn == r_sb[i].dest) || (w_use_rm && w_rm == r_sb[i].dest))) ||
         (w_cls == CLS_BRANCH && w_cond != COND_AL && r_sb[i].sets_flags)));
  end
  assign w_taken = w_cls == CLS_BRANCH && w_cond_ok && !w_hazard;
  assign w_dest  = w_cls == CLS_DP ? w_rd : w_bl ? 4'd14 : 4'd0;
  assign w_wb    = w_cls == CLS_DP ? !(w_opc inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN}) : w_bl && w_taken;
  assign w_nxt   = (w_hazard || w_cls == CLS_BUBBLE) ? sb_entry_t'('0) :
                   {1'b1, w_dest, w_wb, w_cls == CLS_DP && if_id_instruction[20]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb[0] <= '0;
      r_sb[1] <= '0;
      r_pc    <= '0;
      r_ins   <= '0;
      r_stall <= '0;
      r_br    <= '0;
    end else begin
      r_sb[0] <= w_nxt;
      r_sb[1] <= r_sb[0];
      r_pc    <= w_nxt.valid ? if_id_pc : 32'h0;
      r_ins   <= w_hazard ? 32'h0 : if_id_instruction;
      if (w_hazard && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
      if (w_taken && r_br != '1) r_br <= r_br + CNT_W'(1);
    end
  end
  assign freeze            = w_hazard && !rst;
  assign branchTaken       = w_taken && !rst;
  assign flush             = branchTaken;
  assign branchAddr        = if_id_pc + branch_offset(if_id_instruction[23:0]);
  assign id_ex_valid       = r_sb[0].valid;
  assign id_ex_dest        = r_sb[0].dest;
  assign id_ex_wb_en       = r_sb[0].wb_en;
  assign id_ex_pc          = r_pc;
  assign id_ex_instruction = r_ins;
  assign stall_cnt         = r_stall;
  assign branch_cnt        = r_br;
endmodule

// File: tb/tb_id_branch_hazard_unit.sv
// tb_id_branch_hazard_unit: model-checked directed bench for the decode hazard/branch unit
module tb_id_branch_hazard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, ins;
  logic [3:0]  st;
  logic        fz, fl, tk, v;
  logic [31:0] ba, xpc, xins;
  logic [3:0]  xd;
  logic        xw;
  logic [15:0] sc, bc;
  logic        fz2, fl2, tk2, v2;
  logic [31:0] ba2, xpc2, xins2;
  logic [3:0]  xd2;
  logic        xw2;
  logic [1:0]  sc2, bc2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  id_branch_hazard_unit dut (
    .clk(clk), .rst(rst), .if_id_pc(pc), .if_id_instruction(ins), .status(st),
    .freeze(fz), .flush(fl), .branchTaken(tk), .branchAddr(ba),
    .id_ex_valid(v), .id_ex_pc(xpc), .id_ex_instruction(xins), .id_ex_dest(xd), .id_ex_wb_en(xw),
    .stall_cnt(sc), .branch_cnt(bc)
  );
  id_branch_hazard_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .if_id_pc(pc), .if_id_instruction(ins), .status(st),
    .freeze(fz2), .flush(fl2), .branchTaken(tk2), .branchAddr(ba2),
    .id_ex_valid(v2), .id_ex_pc(xpc2), .id_ex_instruction(xins2), .id_ex_dest(xd2), .id_ex_wb_en(xw2),
    .stall_cnt(sc2), .branch_cnt(bc2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, vf, b;
    {n, z, cf, vf} = f;
    if (c >= 4'd14) return c == 4'd14;
    case (c >> 1)
      0: b = z;
      1: b = cf;
      2: b = n;
      3: b = vf;
      4: b = cf && !z;
      5: b = n == vf;
      default: b = !z && (n == vf);
    endcase
    return c[0] ? !b : b;
  endfunction
  typedef struct {bit v; bit [3:0] d; bit w; bit f;} rec_t;
  rec_t hist[$];
  bit m_init = 0;
  bit m_v, m_w;
  bit [3:0] m_d;
  bit [31:0] m_pc, m_ins;
  int m_stall, m_br;
  always @(negedge clk) begin : cmp
    bit bub, br, dp, haz, etk, wb;
    bit [3:0] d;
    int srcs[$];
    int off;
    rec_t r;
    bub = ins == 32'h0;
    br  = !bub && ins[27:25] == 3'b101;
    dp  = !bub && ins[27:26] == 2'b00;
    srcs = {};
    if (dp) begin
      srcs.push_back(int'(ins[19:16]));
      if (!ins[25]) srcs.push_back(int'(ins[3:0]));
    end
    d = dp ? ins[15:12] : (br && ins[24]) ? 4'd14 : 4'd0;
    haz = 0;
    foreach (hist[k]) if (hist[k].v) begin
      foreach (srcs[j]) if (hist[k].w && int'(hist[k].d) == srcs[j]) haz = 1;
      if (br && ins[31:28] != 4'he && hist[k].f) haz = 1;
    end
    etk = br && cond_true(ins[31:28], st) && !haz;
    wb  = dp ? !(ins[24:21] >= 4'd8 && ins[24:21] <= 4'd11) : etk && ins[24];
    off = $signed(ins[23:0]);
    if (m_init) begin
      chk("freeze", fz, !rst && haz);
      chk("flush", fl, !rst && etk);
      chk("branchTaken", tk, !rst && etk);
      chk("branchAddr", ba, pc + 32'(off * 4));
      chk("id_ex_valid", v, m_v);
      chk("id_ex_pc", xpc, m_pc);
      chk("id_ex_instruction", xins, m_ins);
      chk("id_ex_dest", xd, m_d);
      chk("id_ex_wb_en", xw, m_w);
      chk("stall_cnt", sc, m_stall > 65535 ? 65535 : m_stall);
      chk("branch_cnt", bc, m_br > 65535 ? 65535 : m_br);
      chk("w2_freeze", fz2, !rst && haz);
      chk("w2_flush", fl2, !rst && etk);
      chk("w2_taken", tk2, !rst && etk);
      chk("w2_addr", ba2, pc + 32'(off * 4));
      chk("w2_ex", {v2, xd2, xw2}, {m_v, m_d, m_w});
      chk("w2_ex_pc", xpc2, m_pc);
      chk("w2_ex_ins", xins2, m_ins);
      chk("w2_stall_cnt", sc2, m_stall > 3 ? 3 : m_stall);
      chk("w2_branch_cnt", bc2, m_br > 3 ? 3 : m_br);
    end
    if (rst) begin
      hist = {};
      hist.push_back('{0, 0, 0, 0});
      hist.push_back('{0, 0, 0, 0});
      {m_v, m_d, m_w, m_pc, m_ins} = '0;
      m_stall = 0;
      m_br = 0;
      m_init = 1;
    end else if (m_init) begin
      if (haz) begin
        r = '{0, 0, 0, 0};
        m_stall++;
      end else r = '{!bub, bub ? 4'd0 : d, !bub && wb, dp && ins[20]};
      if (etk) m_br++;
      m_v = r.v; m_d = r.d; m_w = r.w;
      m_pc  = r.v ? pc : 32'h0;
      m_ins = haz ? 32'h0 : ins;
      hist.push_front(r);
      void'(hist.pop_back());
    end
  end
  int n;
  logic otk;
  logic [31:0] oad;
  task automatic issue(input logic [31:0] p, input logic [31:0] i, input logic [3:0] s,
                       output int ns, output logic ot, output logic [31:0] oa);
    ns = 0;
    pc = p; ins = i; st = s;
    #2;
    while (fz && ns < 4) begin
      @(posedge clk); #3;
      ns++;
    end
    if (ns >= 4) chk("stall_bound", 32'(ns), 32'd2);
    ot = tk; oa = ba;
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1; pc = 0; ins = 0; st = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_freeze", fz, 0);
    chk("rst_flush", fl, 0);
    chk("rst_taken", tk, 0);
    chk("rst_ex", {v, xd, xw}, 0);
    chk("rst_ex_pc", xpc, 0);
    chk("rst_ex_ins", xins, 0);
    chk("rst_cnts", {sc, bc}, 0);
    repeat (2) issue(0, 0, 0, n, otk, oad);
    issue(32'h10, 32'hE0821003, 0, n, otk, oad);
    issue(32'h14, 32'hE0814005, 0, n, otk, oad);
    chk("raw_stalls", n, 2);
    chk("raw_stall_cnt", sc, 2);
    chk("raw_ex_ins", xins, 32'hE0814005);
    issue(32'h100, 32'hEA000002, 0, n, otk, oad);
    chk("b_taken", otk, 1);
    chk("b_addr", oad, 32'h108);
    chk("b_cnt", bc, 1);
    issue(32'h0, 32'hEAFFFFFF, 0, n, otk, oad);
    chk("b_wrap_addr", oad, 32'hFFFFFFFC);
    issue(32'h20, 32'hE1510002, 0, n, otk, oad);
    chk("cmp_stalls", n, 0);
    issue(32'h200, 32'h0A000004, 4'b0100, n, otk, oad);
    chk("beq_stalls", n, 2);
    chk("beq_taken", otk, 1);
    chk("beq_addr", oad, 32'h210);
    issue(32'h204, 32'h1A000004, 4'b0100, n, otk, oad);
    chk("bne_taken", otk, 0);
    chk("bne_ex", {v, xw}, 2'b10);
    issue(32'h300, 32'hEB000001, 0, n, otk, oad);
    chk("bl_addr", oad, 32'h304);
    chk("bl_ex", {v, xd, xw}, {1'b1, 4'd14, 1'b1});
    issue(32'h304, 32'hE08E1002, 0, n, otk, oad);
    chk("bl_raw_stalls", n, 2);
    issue(32'h308, 32'hE0863007, 0, n, otk, oad);
    issue(32'h30C, 32'hE2898003, 0, n, otk, oad);
    chk("imm_no_rm", n, 0);
    issue(32'h310, 32'hFA000001, 0, n, otk, oad);
    chk("nv_taken", otk, 0);
    repeat (2) issue(0, 0, 0, n, otk, oad);
    repeat (3) begin
      issue(32'h10, 32'hE0821003, 0, n, otk, oad);
      issue(32'h14, 32'hE0814005, 0, n, otk, oad);
    end
    chk("sat_stall16", sc, 12);
    chk("sat_stall2", sc2, 3);
    chk("sat_br16", bc, 4);
    chk("sat_br2", bc2, 3);
    issue(32'h10, 32'hE0821003, 0, n, otk, oad);
    pc = 32'h14; ins = 32'hE0814005;
    #2 chk("mid_freeze", fz, 1);
    @(posedge clk); #3;
    chk("mid_freeze2", fz, 1);
    rst = 1;
    #1 chk("mid_rst_freeze", fz, 0);
    @(posedge clk); #1 rst = 0;
    #2;
    chk("post_rst_freeze", fz, 0);
    chk("post_rst_cnts", {sc, bc}, 0);
    @(posedge clk); #1;
    chk("post_rst_ex", xins, 32'hE0814005);
    chk("post_rst_v", v, 1);
    repeat (3) issue(0, 0, 0, n, otk, oad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
